// File: rtl/ni_request_packetizer.sv
// NI initiator request packetizer: LUT lookup, then head/body/tail flits; optional NI_PACKETIZER_STATS_EN counters.
// Latency: first beat accepted at N gives header valid at N+2; single output register stalls on !flit_ready.
module ni_request_packetizer #(
  parameter int unsigned FLIT_WIDTH   = 80,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PATH_WIDTH   = 7,
  parameter int unsigned TARGET_WIDTH = 4,
  parameter int unsigned BURST_WIDTH  = 4,
  parameter logic [3:0]  SRC_ID       = 4'd0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_cmd,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [BURST_WIDTH-1:0]  req_burst,
  output logic [ADDR_WIDTH-1:0]   lut_address,
  input  logic [PATH_WIDTH-1:0]   lut_path,
  input  logic [TARGET_WIDTH-1:0] transaction_target,
  input  logic                    failed_decoding,
  output logic [FLIT_WIDTH-1:0]   flit_out,
  output logic                    flit_valid,
  input  logic                    flit_ready,
  output logic                    err_valid,
  output logic [ADDR_WIDTH-1:0]   err_addr,
  output logic [15:0]             pkt_count,
  output logic [15:0]             err_count
);

  localparam int HEAD_BIT  = FLIT_WIDTH - 1;
  localparam int TAIL_BIT  = FLIT_WIDTH - 2;
  localparam int BURST_LSB = ADDR_WIDTH;
  localparam int CMD_LSB   = BURST_LSB + BURST_WIDTH;
  localparam int SRC_LSB   = CMD_LSB + 3;
  localparam int TGT_LSB   = SRC_LSB + 4;
  localparam int PATH_LSB  = TGT_LSB + TARGET_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_ROUTE, S_HEADER, S_PAYLOAD, S_DROP} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   lut_address_q, lut_address_d;
  logic [2:0]              cmd_q, cmd_d;
  logic [BURST_WIDTH-1:0]  burst_q, burst_d;
  logic [BURST_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [FLIT_WIDTH-1:0]   flit_q, flit_d;
  logic                    flit_vld_q, flit_vld_d;
  logic                    init_q;
  logic                    is_wr, beats_left;
  logic [BURST_WIDTH-1:0]  beat_nxt;
  logic [FLIT_WIDTH-1:0]   hdr_flit;

  function automatic logic [FLIT_WIDTH-1:0] body_flit(input logic [DATA_WIDTH-1:0] d, input logic tail);
    body_flit = '0;
    body_flit[DATA_WIDTH-1:0] = d;
    body_flit[TAIL_BIT] = tail;
  endfunction

  assign is_wr      = (cmd_q == 3'b001);
  assign beats_left = (beat_cnt_q < burst_q);
  assign beat_nxt   = beat_cnt_q + BURST_WIDTH'(1);

  always_comb begin
    hdr_flit = '0;
    hdr_flit[HEAD_BIT] = 1'b1;
    hdr_flit[TAIL_BIT] = !is_wr;
    hdr_flit[ADDR_WIDTH-1:0] = lut_address_q;
    hdr_flit[CMD_LSB-1:BURST_LSB] = burst_q;
    hdr_flit[SRC_LSB-1:CMD_LSB] = cmd_q;
    hdr_flit[TGT_LSB-1:SRC_LSB] = SRC_ID;
    hdr_flit[PATH_LSB-1:TGT_LSB] = transaction_target;
    hdr_flit[PATH_LSB+PATH_WIDTH-1:PATH_LSB] = lut_path;
  end

  always_comb begin
    state_d       = state_q;
    lut_address_d = lut_address_q;
    cmd_d         = cmd_q;
    burst_d       = burst_q;
    beat_cnt_d    = beat_cnt_q;
    data_d        = data_q;
    flit_d        = flit_q;
    flit_vld_d    = flit_vld_q;
    req_ready     = 1'b0;
    err_valid     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // init_q keeps req_ready low while reset is asserted
        req_ready = init_q;
        if (req_valid && init_q) begin
          lut_address_d = req_addr;
          cmd_d         = req_cmd;
          burst_d       = (req_burst == '0) ? BURST_WIDTH'(1) : req_burst;
          data_d        = req_data;
          beat_cnt_d    = BURST_WIDTH'(1);
          state_d       = S_ROUTE;
        end
      end
      S_ROUTE: begin
        if (failed_decoding) begin
          state_d = S_DROP;
        end else begin
          flit_d     = hdr_flit;
          flit_vld_d = 1'b1;
          state_d    = S_HEADER;
        end
      end
      S_HEADER: begin
        if (flit_ready) begin
          if (is_wr) begin
            flit_d  = body_flit(data_q, burst_q == BURST_WIDTH'(1));
            state_d = S_PAYLOAD;
          end else begin
            flit_d     = '0;
            flit_vld_d = 1'b0;
            state_d    = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        req_ready = beats_left && (!flit_vld_q || flit_ready);
        if (req_valid && req_ready) begin
          flit_d     = body_flit(req_data, beat_nxt == burst_q);
          flit_vld_d = 1'b1;
          beat_cnt_d = beat_nxt;
        end else if (flit_vld_q && flit_ready) begin
          flit_vld_d = 1'b0;
          if (flit_q[TAIL_BIT]) begin
            flit_d  = '0;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        // Remaining write beats are sunk before the error is reported
        if (is_wr && beats_left) begin
          req_ready = 1'b1;
          if (req_valid) beat_cnt_d = beat_nxt;
        end else begin
          err_valid = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      lut_address_q <= '0;
      cmd_q         <= '0;
      burst_q       <= '0;
      beat_cnt_q    <= '0;
      data_q        <= '0;
      flit_q        <= '0;
      flit_vld_q    <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      lut_address_q <= lut_address_d;
      cmd_q         <= cmd_d;
      burst_q       <= burst_d;
      beat_cnt_q    <= beat_cnt_d;
      data_q        <= data_d;
      flit_q        <= flit_d;
      flit_vld_q    <= flit_vld_d;
      init_q        <= 1'b1;
    end
  end

  assign lut_address = lut_address_q;
  assign flit_out    = flit_q;
  assign flit_valid  = flit_vld_q;
  assign err_addr    = err_valid ? lut_address_q : '0;

`ifdef NI_PACKETIZER_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d, err_count_q, err_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    err_count_d = err_count_q;
    if (flit_vld_q && flit_ready && flit_q[TAIL_BIT] && (pkt_count_q != 16'hFFFF))
      pkt_count_d = pkt_count_q + 16'd1;
    if (err_valid && (err_count_q != 16'hFFFF))
      err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ni_request_packetizer.sv
// Directed bench for ni_request_packetizer: table of read lookups plus hand-written write/drop/reset sequences.
module tb_ni_request_packetizer;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_cmd;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_burst;
  logic [31:0] lut_address;
  logic [6:0]  lut_path;
  logic [3:0]  transaction_target;
  logic        failed_decoding;
  logic [79:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;
  logic        err_valid;
  logic [31:0] err_addr;
  logic [15:0] pkt_count;
  logic [15:0] err_count;

  ni_request_packetizer dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_data(req_data), .req_burst(req_burst),
    .lut_address(lut_address), .lut_path(lut_path),
    .transaction_target(transaction_target), .failed_decoding(failed_decoding),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .err_valid(err_valid), .err_addr(err_addr),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  cmd;
    logic [31:0] addr;
    logic [3:0]  burst;
    logic [6:0]  path;
    logic [3:0]  tgt;
    logic        fail;
    logic [79:0] exp_flit;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;

  logic [79:0] got_q[$];
  int          got_cyc[$];
  int          err_pulses;
  logic [31:0] err_addr_seen;
  int          acc_cyc;
  int          first_vld_cyc;
  int          stab_err;
  int          rdy_drop;
  int          evt_cyc;
  logic        post_rdy;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] body(input logic [31:0] d, input logic tail);
    body = '0;
    body[31:0] = d;
    body[78] = tail;
  endfunction

  // Runs one request for ncyc cycles from a slot just after a rising edge.
  // rdy_mode 0: flit_ready held high; 1: flit_ready high on even cycles only.
  task automatic run_packet(input logic [2:0] cmd, input logic [31:0] addr, input logic [3:0] burst_f,
                            input int n_beats, input logic [6:0] path, input logic [3:0] tgt,
                            input logic fail, input int rdy_mode, input int ncyc);
    int          sent;
    logic        hdr_acc;
    logic        prev_stall;
    logic [79:0] prev_flit;
    got_q.delete();
    got_cyc.delete();
    err_pulses = 0; err_addr_seen = '0; acc_cyc = -1; first_vld_cyc = -1;
    stab_err = 0; rdy_drop = 0; evt_cyc = -1; post_rdy = 1'b0;
    sent = 0; hdr_acc = 1'b0; prev_stall = 1'b0; prev_flit = '0;
    lut_path = path; transaction_target = tgt; failed_decoding = fail;
    for (int c = 0; c < ncyc; c++) begin
      flit_ready = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 0);
      if (sent < n_beats) begin
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = (sent == 0) ? addr : 32'hFFFF_FFFF;
        req_burst = (sent == 0) ? burst_f : 4'hF;
        req_data  = 32'(sent + 1);
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (prev_stall && (flit_valid !== 1'b1 || flit_out !== prev_flit)) stab_err++;
      if (rdy_mode == 0 && hdr_acc && sent < n_beats && req_ready !== 1'b1) rdy_drop++;
      if (evt_cyc >= 0 && c == evt_cyc + 1) post_rdy = req_ready;
      if (flit_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = c;
      if (err_valid === 1'b1) begin
        err_pulses++;
        err_addr_seen = err_addr;
        evt_cyc = c;
      end
      if (flit_valid === 1'b1 && flit_ready) begin
        got_q.push_back(flit_out);
        got_cyc.push_back(c);
        hdr_acc = 1'b1;
        if (flit_out[78] === 1'b1) evt_cyc = c;
      end
      prev_stall = (flit_valid === 1'b1) && !flit_ready;
      prev_flit  = flit_out;
      if (req_valid && req_ready === 1'b1) begin
        if (sent == 0) acc_cyc = c;
        sent++;
      end
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    flit_ready = 1'b0;
  endtask

  task automatic chk_write(input string name, input logic [79:0] hdr, input int n_body);
    chk({name, "_nflits"}, 80'(got_q.size()), 80'(n_body + 1));
    if (got_q.size() == n_body + 1) begin
      chk({name, "_hdr"}, got_q[0], hdr);
      for (int i = 0; i < n_body; i++)
        chk($sformatf("%s_body%0d", name, i + 1), got_q[i+1], body(32'(i + 1), i == n_body - 1));
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{3'b010, 32'h1A00_0100, 4'd1, 7'h01, 4'hC, 1'b0, 80'hC000_0000_E021_1A00_0100};
    vecs[1] = '{3'b000, 32'hDEAD_BEEF, 4'd0, 7'h7F, 4'h0, 1'b0, 80'hC000_003F_8001_DEAD_BEEF};
    vecs[2] = '{3'b111, 32'h0000_0004, 4'hF, 7'h00, 4'hF, 1'b0, 80'hC000_0000_787F_0000_0004};
    vecs[3] = '{3'b010, 32'h0000_ABCD, 4'd2, 7'h05, 4'h1, 1'b1, 80'h0};

    reset_n = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0; req_burst = '0;
    lut_path = '0; transaction_target = '0; failed_decoding = 1'b0; flit_ready = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_flit_valid", 80'(flit_valid), 80'd0);
    chk("rst_req_ready", 80'(req_ready), 80'd0);
    chk("rst_err_valid", 80'(err_valid), 80'd0);
    chk("rst_lut_address", 80'(lut_address), 80'd0);
    chk("rst_flit_out", flit_out, 80'd0);
    #19 reset_n = 1'b1;
    @(posedge clock); #1;

    // Single-flit reads and a failed lookup, table driven
    for (int v = 0; v < 4; v++) begin
      run_packet(vecs[v].cmd, vecs[v].addr, vecs[v].burst, 1, vecs[v].path, vecs[v].tgt,
                 vecs[v].fail, 0, 8);
      chk($sformatf("v%0d_lut_address", v), 80'(lut_address), 80'(vecs[v].addr));
      chk($sformatf("v%0d_post_ready", v), 80'(post_rdy), 80'd1);
      if (!vecs[v].fail) begin
        chk($sformatf("v%0d_nflits", v), 80'(got_q.size()), 80'd1);
        if (got_q.size() > 0) chk($sformatf("v%0d_flit", v), got_q[0], vecs[v].exp_flit);
        chk($sformatf("v%0d_latency", v), 80'(first_vld_cyc - acc_cyc), 80'd2);
      end else begin
        chk($sformatf("v%0d_nflits", v), 80'(got_q.size()), 80'd0);
        chk($sformatf("v%0d_err_pulses", v), 80'(err_pulses), 80'd1);
        chk($sformatf("v%0d_err_addr", v), 80'(err_addr_seen), 80'(vecs[v].addr));
      end
    end

    // Write burst 4 at full throughput
    run_packet(3'b001, 32'h1A00_0000, 4'd4, 4, 7'h02, 4'h3, 1'b0, 0, 20);
    chk_write("wr4", 80'h8000_0001_1814_1A00_0000, 4);
    chk("wr4_latency", 80'(first_vld_cyc - acc_cyc), 80'd2);
    if (got_cyc.size() == 5) chk("wr4_no_bubble", 80'(got_cyc[4] - got_cyc[0]), 80'd4);
    chk("wr4_rdy_drop", 80'(rdy_drop), 80'd0);
    chk("wr4_post_ready", 80'(post_rdy), 80'd1);

    // Same write with flit_ready toggling
    run_packet(3'b001, 32'h1A00_0000, 4'd4, 4, 7'h02, 4'h3, 1'b0, 1, 30);
    chk_write("wr4t", 80'h8000_0001_1814_1A00_0000, 4);
    chk("wr4t_stable", 80'(stab_err), 80'd0);

    // Dropped write burst 3 sinks two more beats then reports
    run_packet(3'b001, 32'h0000_1000, 4'd3, 3, 7'h01, 4'h1, 1'b1, 0, 12);
    chk("drop_nflits", 80'(got_q.size()), 80'd0);
    chk("drop_err_pulses", 80'(err_pulses), 80'd1);
    chk("drop_err_addr", 80'(err_addr_seen), 80'h0000_1000);
    chk("drop_post_ready", 80'(post_rdy), 80'd1);

    run_packet(vecs[0].cmd, vecs[0].addr, vecs[0].burst, 1, vecs[0].path, vecs[0].tgt, 1'b0, 0, 8);
    chk("after_drop_nflits", 80'(got_q.size()), 80'd1);
    if (got_q.size() > 0) chk("after_drop_flit", got_q[0], vecs[0].exp_flit);

    // Burst field 0 behaves as a single-beat write
    run_packet(3'b001, 32'h0000_2000, 4'd0, 1, 7'h01, 4'h2, 1'b0, 0, 10);
    chk_write("wr0", 80'h8000_0000_9011_0000_2000, 1);

    chk("pkt_count_default", 80'(pkt_count), 80'd0);
    chk("err_count_default", 80'(err_count), 80'd0);

    // Reset in the middle of a burst-8 payload
    run_packet(3'b001, 32'h0000_3000, 4'd8, 8, 7'h01, 4'h1, 1'b0, 0, 6);
    chk("midrst_pre_valid", 80'(flit_valid), 80'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_flit_valid", 80'(flit_valid), 80'd0);
    chk("midrst_req_ready", 80'(req_ready), 80'd0);
    chk("midrst_flit_out", flit_out, 80'd0);
    chk("midrst_lut_address", 80'(lut_address), 80'd0);
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    run_packet(vecs[0].cmd, vecs[0].addr, vecs[0].burst, 1, vecs[0].path, vecs[0].tgt, 1'b0, 0, 8);
    chk("postrst_nflits", 80'(got_q.size()), 80'd1);
    if (got_q.size() > 0) chk("postrst_flit", got_q[0], vecs[0].exp_flit);
    chk("postrst_latency", 80'(first_vld_cyc - acc_cyc), 80'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
